// File: rtl/pwm_bank_pkg.sv
// Shared types and helpers for the pwm_bank multi-channel PWM generator.
// The signed-duty helpers are used only when PWM_BANK_SIGNED_EN is defined.
package pwm_bank_pkg;

  // Prescaler and period counter; sized for the widest supported configuration.
  typedef struct packed {
    logic [31:0] pre;
    logic [15:0] cnt;
  } timebase_t;

  // Last counter value of a period: 2^width - 2, giving a 2^width - 1 tick period.
  function automatic logic [15:0] maxc(input int unsigned width);
    return 16'((32'd1 << width) - 32'd2);
  endfunction

  // Magnitude of a width-bit two's-complement value, saturated to 2^(width-1) - 1.
  function automatic logic [15:0] abs_sat(input logic [15:0] val, input int unsigned width);
    logic [31:0] mask;
    logic [31:0] half;
    logic [31:0] v;
    logic [31:0] mag;
    mask = (32'd1 << width) - 32'd1;
    half = 32'd1 << (width - 1);
    v    = 32'(val) & mask;
    if (v >= half) begin
      mag = (~v + 32'd1) & mask;
    end else begin
      mag = v;
    end
    if (mag >= half) begin
      mag = half - 32'd1;
    end
    return 16'(mag);
  endfunction

  // Magnitude to effective duty: doubled, with the top magnitude mapping to 100%.
  function automatic logic [15:0] mag_to_duty(input logic [15:0] mag, input int unsigned width);
    logic [31:0] full;
    logic [31:0] top;
    full = (32'd1 << width) - 32'd1;
    top  = (32'd1 << (width - 1)) - 32'd1;
    if (32'(mag) == top) begin
      return 16'(full);
    end
    return 16'({16'd0, mag} << 1);
  endfunction

endpackage

// File: rtl/pwm_bank_channel.sv
// One PWM channel: shadow/active duty registers and the registered compare.
// With PWM_BANK_SIGNED_EN defined, duties are two's-complement and driven by magnitude.
module pwm_bank_channel
  import pwm_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] duty_i,
  input  logic             load_i,
  input  logic             wrap_i,
  input  logic             pending_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] cnt_i,
  output logic             pwm_o
);

  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] active_q;
  logic             pwm_q;
  logic [WIDTH-1:0] duty_eff;
  logic [WIDTH-1:0] shadow_eff;

`ifdef PWM_BANK_SIGNED_EN
  // Conversion sits in front of the active register so it costs no cycle.
  logic [15:0] duty_full;
  logic [15:0] shadow_full;

  always_comb begin
    duty_full   = mag_to_duty(abs_sat(16'(duty_i), WIDTH), WIDTH);
    shadow_full = mag_to_duty(abs_sat(16'(shadow_q), WIDTH), WIDTH);
    duty_eff    = WIDTH'(duty_full);
    shadow_eff  = WIDTH'(shadow_full);
  end
`else
  always_comb begin
    duty_eff   = duty_i;
    shadow_eff = shadow_q;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      active_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      if (load_i && wrap_i) begin
        // Load coinciding with the boundary bypasses the shadow stage.
        shadow_q <= duty_i;
        active_q <= duty_eff;
      end else if (load_i) begin
        shadow_q <= duty_i;
      end else if (wrap_i && pending_i) begin
        active_q <= shadow_eff;
      end
      pwm_q <= enable_i && (active_q > cnt_i);
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM bank: shared prescaler/period counter, per-channel double-buffered duty.
// Define PWM_BANK_SIGNED_EN to treat duties as two's-complement magnitudes.
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int unsigned NUM_CH   = 8,
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned PRESCALE = 49
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET_N,
  input  logic [NUM_CH*WIDTH-1:0] duty_in,
  input  logic                    load,
  input  logic [NUM_CH-1:0]       enable,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    update_pending,
  output logic                    period_start
);

  localparam logic [15:0] MaxC = maxc(WIDTH);

  timebase_t tb_q;
  timebase_t tb_d;
  logic      tick;
  logic      wrap;
  logic      update_pending_q;
  logic      period_start_q;

  always_comb begin
    tick = (tb_q.pre == PRESCALE);
    wrap = tick && (tb_q.cnt == MaxC);
    tb_d = tb_q;
    if (tick) begin
      tb_d.pre = '0;
      tb_d.cnt = wrap ? 16'd0 : tb_q.cnt + 16'd1;
    end else begin
      tb_d.pre = tb_q.pre + 32'd1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      tb_q             <= '0;
      update_pending_q <= 1'b0;
      period_start_q   <= 1'b0;
    end else begin
      tb_q           <= tb_d;
      period_start_q <= wrap;
      if (load && !wrap) begin
        update_pending_q <= 1'b1;
      end else if (wrap) begin
        update_pending_q <= 1'b0;
      end
    end
  end

  assign update_pending = update_pending_q;
  assign period_start   = period_start_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : gen_ch
    pwm_bank_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk_i    (CLOCK_50),
      .rst_ni   (RESET_N),
      .duty_i   (duty_in[k*WIDTH +: WIDTH]),
      .load_i   (load),
      .wrap_i   (wrap),
      .pending_i(update_pending_q),
      .enable_i (enable[k]),
      .cnt_i    (tb_q.cnt[WIDTH-1:0]),
      .pwm_o    (pwm_out[k])
    );
  end

endmodule
